// File: rtl/fft_input_loader_pkg.sv
// Shared FFT definitions: frame size, complex word layout and the bit-reverse helper.
// Both the loader and the butterfly stages import these definitions.
package fft_input_loader_pkg;

    localparam int FFT_N_PTS  = 16;
    localparam int FFT_CW     = 64;
    localparam int FFT_AW     = 4;

    // Real part in the upper half, imaginary part in the lower half (IEEE-754 single each).
    localparam int FFT_RE_MSB = 63;
    localparam int FFT_RE_LSB = 32;
    localparam int FFT_IM_MSB = 31;
    localparam int FFT_IM_LSB = 0;

    function automatic logic [FFT_AW-1:0] bitrev4(input logic [FFT_AW-1:0] idx);
        logic [FFT_AW-1:0] r;
        for (int b = 0; b < FFT_AW; b++) begin
            r[b] = idx[FFT_AW-1-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_input_loader_bitrev_addr.sv
// Decodes a natural-order sample index into a one-hot write enable
// addressing the bit-reversed output slot.
module fft_bitrev_addr
    import fft_input_loader_pkg::*;
(
    input  logic [FFT_AW-1:0]    idx,
    input  logic                 en,
    output logic [FFT_N_PTS-1:0] we
);

    logic [FFT_AW-1:0] slot;

    assign slot = bitrev4(idx);

    generate
        for (genvar gi = 0; gi < FFT_N_PTS; gi++) begin : g_we
            assign we[gi] = en && (slot == FFT_AW'(gi));
        end
    endgenerate

endmodule

// File: rtl/fft_input_loader.sv
// Collects 16 serial complex samples and presents them as a parallel,
// bit-reversed frame for the first butterfly stage, with framing-error detection.
module fft_input_loader
    import fft_input_loader_pkg::*;
#(
    parameter int N_PTS = 16,   // only 16 is supported
    parameter int CW    = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [CW-1:0] in_data,
    input  logic          in_valid,
    input  logic          in_last,
    output logic          in_ready,
    output logic [CW-1:0] o0,
    output logic [CW-1:0] o1,
    output logic [CW-1:0] o2,
    output logic [CW-1:0] o3,
    output logic [CW-1:0] o4,
    output logic [CW-1:0] o5,
    output logic [CW-1:0] o6,
    output logic [CW-1:0] o7,
    output logic [CW-1:0] o8,
    output logic [CW-1:0] o9,
    output logic [CW-1:0] o10,
    output logic [CW-1:0] o11,
    output logic [CW-1:0] o12,
    output logic [CW-1:0] o13,
    output logic [CW-1:0] o14,
    output logic [CW-1:0] o15,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          err
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [FFT_AW-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic [CW-1:0]     slot_q [N_PTS];
    logic [CW-1:0]     slot_d [N_PTS];
    logic              accept;
    logic [N_PTS-1:0]  we;

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == HOLD);
    assign accept    = in_valid && in_ready;
    assign err       = err_q;

    fft_bitrev_addr u_bitrev_addr (
        .idx (cnt_q),
        .en  (accept),
        .we  (we)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    if (cnt_q == FFT_AW'(N_PTS - 1)) begin
                        state_d = HOLD;
                        cnt_d   = '0;
                        err_d   = !in_last;
                    end else if (in_last) begin
                        // Short frame: drop it and restart; the partial slots are never presented.
                        cnt_d = '0;
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    generate
        for (genvar gi = 0; gi < N_PTS; gi++) begin : g_slot
            assign slot_d[gi] = we[gi] ? in_data : slot_q[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < N_PTS; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            slot_q  <= slot_d;
        end
    end

    assign o0  = slot_q[0];
    assign o1  = slot_q[1];
    assign o2  = slot_q[2];
    assign o3  = slot_q[3];
    assign o4  = slot_q[4];
    assign o5  = slot_q[5];
    assign o6  = slot_q[6];
    assign o7  = slot_q[7];
    assign o8  = slot_q[8];
    assign o9  = slot_q[9];
    assign o10 = slot_q[10];
    assign o11 = slot_q[11];
    assign o12 = slot_q[12];
    assign o13 = slot_q[13];
    assign o14 = slot_q[14];
    assign o15 = slot_q[15];

endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench for fft_input_loader: directed ramp/backpressure/framing/reset
// sequences plus randomized back-to-back frames against a frame-level reference model.
module tb_fft_input_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic        out_valid;
    logic        out_ready;
    logic        err;
    logic [63:0] o0, o1, o2, o3, o4, o5, o6, o7, o8, o9, o10, o11, o12, o13, o14, o15;
    logic [63:0] obs [16];

    always #5 clk = ~clk;

    fft_input_loader #(.N_PTS(16), .CW(64)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .o0(o0), .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7),
        .o8(o8), .o9(o9), .o10(o10), .o11(o11), .o12(o12), .o13(o13), .o14(o14), .o15(o15),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    assign obs = '{o0, o1, o2, o3, o4, o5, o6, o7, o8, o9, o10, o11, o12, o13, o14, o15};

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a frame is the list of accepted samples; a complete list of
    // 16 is scattered to bit-reversed slots, anything shorter is discarded.
    logic [63:0] m_frame [$];
    logic [63:0] m_slots [16];
    bit          m_hold;
    bit          m_err;
    bit          m_zero;
    int          frames_done;

    typedef struct {
        int          slot;
        int          src;
        logic [63:0] exp;
    } ramp_t;
    ramp_t       tbl [16];
    logic [31:0] fl [16];

    function automatic int rev4(input int n);
        int r = 0;
        for (int b = 0; b < 4; b++) begin
            if ((n >> b) & 1) r += 1 << (3 - b);
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit r_n, input bit v, input bit l, input bit r,
                              input logic [63:0] d);
        m_err = 1'b0;
        if (!r_n) begin
            m_hold = 1'b0;
            m_zero = 1'b1;
            m_frame.delete();
            for (int k = 0; k < 16; k++) m_slots[k] = '0;
        end else if (!m_hold) begin
            if (v) begin
                m_zero = 1'b0;
                m_frame.push_back(d);
                if (m_frame.size() == 16) begin
                    for (int k = 0; k < 16; k++) m_slots[rev4(k)] = m_frame[k];
                    m_frame.delete();
                    m_hold = 1'b1;
                    m_err  = !l;
                    frames_done++;
                end else if (l) begin
                    m_frame.delete();
                    m_err = 1'b1;
                end
            end
        end else if (r) begin
            m_hold = 1'b0;
        end
    endtask

    // Drive one cycle, advance the model at the edge, then compare just after it.
    task automatic cyc(input bit r_n, input bit v, input bit l, input bit r,
                       input logic [63:0] d);
        rst_n     = r_n;
        in_valid  = v;
        in_last   = l;
        out_ready = r;
        in_data   = d;
        @(posedge clk);
        model_step(r_n, v, l, r, d);
        #1;
        chk("in_ready", {63'b0, in_ready}, {63'b0, !m_hold});
        chk("out_valid", {63'b0, out_valid}, {63'b0, m_hold});
        chk("err", {63'b0, err}, {63'b0, m_err});
        if (m_hold || m_zero) begin
            for (int k = 0; k < 16; k++) begin
                if (obs[k] !== m_slots[k]) chk($sformatf("slot%0d", k), obs[k], m_slots[k]);
            end
            n_checks++;
        end
    endtask

    task automatic send_frame(input int count, input int last_at, input bit r);
        for (int n = 0; n < count; n++) begin
            cyc(1'b1, 1'b1, n == last_at, r, {$urandom, $urandom});
        end
    endtask

    initial begin
        fl = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
               32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000,
               32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000,
               32'h41400000, 32'h41500000, 32'h41600000, 32'h41700000};
        tbl[0]  = '{0,  0,  {32'h00000000, 32'h0}};
        tbl[1]  = '{1,  8,  {32'h41000000, 32'h0}};
        tbl[2]  = '{2,  4,  {32'h40800000, 32'h0}};
        tbl[3]  = '{3,  12, {32'h41400000, 32'h0}};
        tbl[4]  = '{4,  2,  {32'h40000000, 32'h0}};
        tbl[5]  = '{5,  10, {32'h41200000, 32'h0}};
        tbl[6]  = '{6,  6,  {32'h40C00000, 32'h0}};
        tbl[7]  = '{7,  14, {32'h41600000, 32'h0}};
        tbl[8]  = '{8,  1,  {32'h3F800000, 32'h0}};
        tbl[9]  = '{9,  9,  {32'h41100000, 32'h0}};
        tbl[10] = '{10, 5,  {32'h40A00000, 32'h0}};
        tbl[11] = '{11, 13, {32'h41500000, 32'h0}};
        tbl[12] = '{12, 3,  {32'h40400000, 32'h0}};
        tbl[13] = '{13, 11, {32'h41300000, 32'h0}};
        tbl[14] = '{14, 7,  {32'h40E00000, 32'h0}};
        tbl[15] = '{15, 15, {32'h41700000, 32'h0}};
        m_hold = 1'b0; m_err = 1'b0; m_zero = 1'b1; frames_done = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; in_data = '0;

        // Reset: all outputs zero, ready on the first cycle out of reset.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, '1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0);

        // Ramp: float(n) real parts, last on index 15, out_ready high throughout.
        for (int n = 0; n < 16; n++) cyc(1'b1, 1'b1, n == 15, 1'b1, {fl[n], 32'h0});
        for (int i = 0; i < 16; i++) chk($sformatf("ramp_o%0d_src%0d", tbl[i].slot, tbl[i].src),
                                         obs[tbl[i].slot], tbl[i].exp);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, '0);

        // Backpressure: hold for 10 cycles with in_valid asserted, then release.
        send_frame(16, 15, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, {$urandom, $urandom});
        cyc(1'b1, 1'b1, 1'b0, 1'b1, {$urandom, $urandom});
        chk("bp_in_ready_after_release", {63'b0, in_ready}, 64'd1);

        // Early last on index 5, then a clean frame.
        send_frame(6, 5, 1'b1);
        send_frame(16, 15, 1'b1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, '0);

        // Missing last: frame still delivered, one err pulse.
        send_frame(16, -1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, '0);

        // Reset mid-fill after 7 samples, then a full frame from index 0.
        send_frame(7, -1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0);
        send_frame(16, 15, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, '0);

        // Randomized back-to-back frames with valid gaps and random out_ready.
        begin
            int target = frames_done + 3;
            int budget = 2000;
            while (frames_done < target && budget > 0) begin
                bit v = ($urandom_range(0, 3) != 0);
                cyc(1'b1, v, m_frame.size() == 15, $urandom_range(0, 1) == 1,
                    {$urandom, $urandom});
                budget--;
            end
            n_checks++;
            if (frames_done < target) begin
                n_errors++;
                $display("FAIL random_frames actual=%0d required=%0d", frames_done, target);
            end
            for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, '0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
